// File: rtl/seq_mul10_pkg.sv
// Shared definitions for the sequenced 10x10 multiplier: core width, FSM states
// and the shift applied to each partial product.
package seq_mul10_pkg;

    localparam int CORE_W = 5;
    localparam int OP_W   = 2 * CORE_W;
    localparam int PP_W   = 2 * CORE_W;
    localparam int ACC_W  = 4 * CORE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [1:0] step_t;

    localparam logic [3:0] SHIFT_S0 = 4'd0;
    localparam logic [3:0] SHIFT_S1 = 4'd5;
    localparam logic [3:0] SHIFT_S2 = 4'd5;
    localparam logic [3:0] SHIFT_S3 = 4'd10;

    function automatic logic [3:0] step_shift(input step_t step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = SHIFT_S0;
            2'd1:    sh = SHIFT_S1;
            2'd2:    sh = SHIFT_S2;
            default: sh = SHIFT_S3;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/seq_mul10_ctrl_wallace5.sv
// 5x5 unsigned Wallace tree multiplier: three carry-save stages compress the
// five partial-product rows to two, then one carry-propagate add.
module seq_mul10_ctrl_wallace5
    import seq_mul10_pkg::*;
(
    input  logic [CORE_W-1:0] x,
    input  logic [CORE_W-1:0] y,
    output logic [PP_W-1:0]   p
);

    logic [PP_W-1:0] row [CORE_W];
    logic [PP_W-1:0] s1, c1, s2, c2, s3, c3;

    function automatic logic [2*PP_W-1:0] csa(input logic [PP_W-1:0] u,
                                              input logic [PP_W-1:0] v,
                                              input logic [PP_W-1:0] w);
        logic [PP_W-1:0] sum;
        logic [PP_W-1:0] carry;
        sum   = u ^ v ^ w;
        carry = ((u & v) | (u & w) | (v & w)) << 1;
        return {carry, sum};
    endfunction

    always_comb begin
        for (int i = 0; i < CORE_W; i++) begin
            row[i] = {{CORE_W{1'b0}}, x & {CORE_W{y[i]}}} << i;
        end
    end

    // The true product never exceeds 10 bits, so truncating carries is exact.
    assign {c1, s1} = csa(row[0], row[1], row[2]);
    assign {c2, s2} = csa(s1, c1, row[3]);
    assign {c3, s3} = csa(s2, c2, row[4]);
    assign p        = s3 + c3;

endmodule

// File: rtl/seq_mul10_ctrl.sv
// 10x10 unsigned multiply built from four passes through one shared 5x5 core,
// shift-accumulated into a 20-bit result behind valid/ready handshakes.
module seq_mul10_ctrl #(
    parameter int CORE_W   = 5,
    parameter int ACC_PIPE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*CORE_W-1:0]   a,
    input  logic [2*CORE_W-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*CORE_W-1:0]   product,
    output logic                  busy
);

    import seq_mul10_pkg::state_e;
    import seq_mul10_pkg::step_t;
    import seq_mul10_pkg::ST_IDLE;
    import seq_mul10_pkg::ST_MUL;
    import seq_mul10_pkg::ST_DONE;
    import seq_mul10_pkg::step_shift;

    localparam int OPW = 2 * CORE_W;
    localparam int ACW = 4 * CORE_W;

    state_e          state_q, state_d;
    step_t           step_q, step_d;
    logic [OPW-1:0]  a_q, a_d, b_q, b_d;
    logic [ACW-1:0]  acc_q, acc_d;
    logic [OPW-1:0]  pp_q, pp_d;
    logic [3:0]      pp_shift_q, pp_shift_d;
    logic            pp_vld_q, pp_vld_d;
    logic            pp_last_q, pp_last_d;
    logic            issued_q, issued_d;

    logic [CORE_W-1:0] core_x, core_y;
    logic [OPW-1:0]    core_p;
    logic              accept;

    // Step selects which operand halves feed the shared core.
    always_comb begin
        core_x = a_q[CORE_W-1:0];
        core_y = b_q[CORE_W-1:0];
        case (step_q)
            2'd1: core_x = a_q[OPW-1:CORE_W];
            2'd2: core_y = b_q[OPW-1:CORE_W];
            2'd3: begin
                core_x = a_q[OPW-1:CORE_W];
                core_y = b_q[OPW-1:CORE_W];
            end
            default: ;
        endcase
    end

    seq_mul10_ctrl_wallace5 u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign product   = acc_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d    = state_q;
        step_d     = step_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        pp_d       = pp_q;
        pp_shift_d = pp_shift_q;
        pp_vld_d   = 1'b0;
        pp_last_d  = pp_last_q;
        issued_d   = issued_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d      = a;
                    b_d      = b;
                    acc_d    = '0;
                    step_d   = 2'd0;
                    issued_d = 1'b0;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                if (ACC_PIPE == 0) begin
                    acc_d  = acc_q + (ACW'(core_p) << step_shift(step_q));
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) state_d = ST_DONE;
                end else begin
                    // The registered product is folded in one edge after it is issued.
                    if (pp_vld_q) begin
                        acc_d = acc_q + (ACW'(pp_q) << pp_shift_q);
                        if (pp_last_q) state_d = ST_DONE;
                    end
                    if (!issued_q) begin
                        pp_d       = core_p;
                        pp_shift_d = step_shift(step_q);
                        pp_vld_d   = 1'b1;
                        pp_last_d  = (step_q == 2'd3);
                        step_d     = step_q + 2'd1;
                        issued_d   = (step_q == 2'd3);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            step_d   = 2'd0;
            pp_vld_d = 1'b0;
            issued_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            pp_q       <= '0;
            pp_shift_q <= 4'd0;
            pp_vld_q   <= 1'b0;
            pp_last_q  <= 1'b0;
            issued_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            pp_q       <= pp_d;
            pp_shift_q <= pp_shift_d;
            pp_vld_q   <= pp_vld_d;
            pp_last_q  <= pp_last_d;
            issued_q   <= issued_d;
        end
    end

endmodule

// File: tb/tb_seq_mul10_ctrl.sv
// Directed bench for seq_mul10_ctrl: one instance without and one with the
// accumulator pipeline register, checked against hand-computed products.
module tb_seq_mul10_ctrl;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [9:0]  a;
    logic [9:0]  b;
    logic        out_ready;

    logic        in_valid0, in_ready0, out_valid0, busy0;
    logic [19:0] product0;
    logic        in_valid1, in_ready1, out_valid1, busy1;
    logic [19:0] product1;

    int checks = 0;
    int errors = 0;

    seq_mul10_ctrl #(.CORE_W(5), .ACC_PIPE(0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .product   (product0),
        .busy      (busy0)
    );

    seq_mul10_ctrl #(.CORE_W(5), .ACC_PIPE(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .product   (product1),
        .busy      (busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input bit pipe, input logic [9:0] av, input logic [9:0] bv);
        a = av;
        b = bv;
        if (pipe) in_valid1 = 1'b1;
        else      in_valid0 = 1'b1;
        check("in_ready_before_accept", pipe ? in_ready1 : in_ready0, 1);
        step();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_out(input bit pipe, output int n);
        n = 0;
        while (!(pipe ? out_valid1 : out_valid0) && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        bit seen;

        reset     = 1'b1;
        flush     = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready",  in_ready0,  1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_product",   product0,   0);
        check("rst_busy",      busy0,      0);
        step();
        reset = 1'b0;
        step();

        // Max operands, 4-cycle latency
        accept(0, 10'd1023, 10'd1023);
        check("max_busy", busy0, 1);
        wait_out(0, n);
        check("max_latency", n, 4);
        check("max_product", product0, 32'hFF801);
        check("max_in_ready_done", in_ready0, 0);
        step();
        check("max_out_valid_after_hs", out_valid0, 0);
        check("max_in_ready_after_hs",  in_ready0,  1);

        // Back-to-back: second op waits for the first handshake; a/b changes while busy ignored
        accept(0, 10'd37, 10'd600);
        a = 10'd0;
        b = 10'd777;
        in_valid0 = 1'b1;
        wait_out(0, n);
        check("b2b_first_latency", n, 4);
        check("b2b_first_product", product0, 22200);
        check("b2b_in_ready_while_done", in_ready0, 0);
        step();
        check("b2b_out_valid_after_hs", out_valid0, 0);
        check("b2b_idle_after_hs", busy0, 0);
        step();
        in_valid0 = 1'b0;
        check("b2b_second_accepted", busy0, 1);
        wait_out(0, n);
        check("b2b_second_latency", n, 4);
        check("b2b_second_product", product0, 0);
        step();

        // Backpressure
        out_ready = 1'b0;
        accept(0, 10'd512, 10'd31);
        wait_out(0, n);
        check("bp_latency", n, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_out_valid_held", out_valid0, 1);
            check("bp_product_held",   product0,   15872);
            check("bp_in_ready_low",   in_ready0,  0);
        end
        out_ready = 1'b1;
        step();
        check("bp_out_valid_after_hs", out_valid0, 0);
        check("bp_in_ready_after_hs",  in_ready0,  1);

        // Flush at step 2, then flush together with in_valid in IDLE
        accept(0, 10'd300, 10'd300);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle",      busy0,      0);
        check("flush_in_ready",  in_ready0,  1);
        check("flush_out_valid", out_valid0, 0);
        a = 10'd9;
        b = 10'd9;
        in_valid0 = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid0 = 1'b0;
        check("flush_blocks_accept", busy0, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | out_valid0;
        end
        check("flush_no_result", seen, 0);
        accept(0, 10'd5, 10'd7);
        wait_out(0, n);
        check("post_flush_latency", n, 4);
        check("post_flush_product", product0, 35);
        step();

        // Asynchronous reset mid-operation
        accept(0, 10'd1023, 10'd1023);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_in_ready",  in_ready0,  1);
        check("arst_out_valid", out_valid0, 0);
        check("arst_product",   product0,   0);
        check("arst_busy",      busy0,      0);
        #1 reset = 1'b0;
        step();
        accept(0, 10'd100, 10'd200);
        wait_out(0, n);
        check("post_arst_latency", n, 4);
        check("post_arst_product", product0, 20000);
        step();

        // Pipelined accumulator: 5-cycle latency
        accept(1, 10'd1000, 10'd999);
        wait_out(1, n);
        check("pipe_latency", n, 5);
        check("pipe_product", product1, 999000);
        step();
        check("pipe_out_valid_after_hs", out_valid1, 0);
        accept(1, 10'd1023, 10'd1023);
        wait_out(1, n);
        check("pipe_max_latency", n, 5);
        check("pipe_max_product", product1, 32'hFF801);
        step();
        check("pipe_in_ready_after_hs", in_ready1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mul10_ctrl.md
Name: seq_mul10_ctrl

Overview:
- Sequencing controller that computes a 10x10 unsigned product using one shared 5x5 Wallace tree multiplier core.
- Issues four partial products over successive cycles and shift-accumulates them into a 20-bit result.
- Valid/ready handshake on both the operand side and the result side.
- Sits between the team's operand source and downstream logic wherever a wider multiply is needed without replicating the tree.

Parameters:
- CORE_W, 5, core operand width; fixed at 5; operand width is 2*CORE_W.
- ACC_PIPE, 0, 1 inserts a register between core output and accumulator (+1 cycle latency, shorter path).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; returns all state and outputs to reset values immediately.
- flush  input  1  synchronous abort; drops any in-flight or completed op.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  controller can accept operands.
- a  input  10  multiplicand, unsigned.
- b  input  10  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  20  a*b, unsigned.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, MUL, DONE.
- Reset values: state=IDLE, step=0, acc=0, product=0, out_valid=0, busy=0, in_ready=1 (combinational from state).
- in_ready = (state==IDLE). Accept = in_valid & in_ready at a rising edge. On accept:
  - latch a and b
  - clear acc
  - step=0
  - state→MUL
- Operand split: ah=a[9:5], al=a[4:0], bh=b[9:5], bl=b[4:0].
- Core operand mux by step:
  - step0: al*bl, shift 0
  - step1: ah*bl, shift 5
  - step2: al*bh, shift 5
  - step3: ah*bh, shift 10
- Core 10-bit product is zero-extended. Core carry-out is ignored; a 5x5 product fits in 10 bits.
- ACC_PIPE=0: each MUL edge does acc += pp<<shift and step++. The edge with step==3 moves state→DONE.
  - Latency: out_valid rises 4 cycles after the accept edge.
- ACC_PIPE=1: the partial product register loads on MUL edges; acc adds the registered value one edge later. state→DONE on the edge after step3 is accumulated.
  - Latency: 5 cycles.
- acc is 20 bits. Overflow is impossible; max is 1023*1023 = 0xFF801.
- DONE: out_valid=1 and product=acc, held stable until out_ready.
  - out_valid & out_ready at an edge → state IDLE, out_valid=0.
  - No accept occurs on that same edge, because in_ready is low in DONE.
  - Throughput: one op per 6 cycles (ACC_PIPE=0) with out_ready held high.
- Backpressure: out_ready low keeps DONE indefinitely. product, out_valid and in_ready are unchanged.
- flush (highest synchronous priority):
  - next edge → IDLE, out_valid=0, step=0.
  - acc is not cleared (don't-care).
  - flush together with in_valid in IDLE: no accept.
- Async reset mid-op: immediate IDLE, out_valid=0, product=0. No result is ever emitted for the aborted op.
- Inputs a/b are sampled only at accept; changes while busy have no effect.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, MUL=2'd1, DONE=2'd2)
  - step shift-amount constants
  - CORE_W
- One sub-module: the existing 5x5 Wallace tree multiplier core, instantiated once and unmodified.
- Operand mux, FSM and accumulator stay in seq_mul10_ctrl.

Test Plan:
- a=1023, b=1023, out_ready=1, ACC_PIPE=0 → out_valid exactly 4 cycles after accept, product=20'hFF801, in_ready returns high the cycle after handshake.
- a=37, b=600, then a=0, b=777 back-to-back → products 22200 then 0, second accept only after first out handshake.
- a=512, b=31 with out_ready low for 3 cycles after out_valid → product=15872 held stable, in_ready=0 throughout, one handshake when out_ready rises.
- a=300, b=300, flush asserted at step2 → IDLE next edge, out_valid never asserted; new op a=5, b=7 then yields product=35.
- Async reset asserted mid-MUL between clock edges → in_ready=1, out_valid=0, product=0 immediately; a subsequent op completes correctly.
- ACC_PIPE=1, a=1000, b=999 → product=999000, out_valid 5 cycles after accept.
